// File: rtl/switch_pkg.sv
// Shared definitions for the 7-port switch: port numbering, priority width
// and the port-index type used by the arbiter and its round-robin picker.
package switch_pkg;

  localparam int NUM_PORTS      = 7;
  localparam int PRIORITY_WIDTH = 8;

  typedef logic [2:0] port_idx_t;

  localparam port_idx_t PORT_LOCAL = 3'd0;
  localparam port_idx_t PORT_YNEG  = 3'd1;
  localparam port_idx_t PORT_YPOS  = 3'd2;
  localparam port_idx_t PORT_XPOS  = 3'd3;
  localparam port_idx_t PORT_XNEG  = 3'd4;
  localparam port_idx_t PORT_ZPOS  = 3'd5;
  localparam port_idx_t PORT_ZNEG  = 3'd6;

  // Round-robin successor of a port; the last port wraps back to local.
  function automatic port_idx_t next_port(input port_idx_t p);
    if (p == PORT_ZNEG) begin
      return PORT_LOCAL;
    end else begin
      return p + 3'd1;
    end
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of cand found scanning
// from rr_ptr upward, modulo NumPorts.
module rr_pick
  import switch_pkg::*;
#(
  parameter int NumPorts = NUM_PORTS
) (
  input  logic [NumPorts-1:0] cand,
  input  port_idx_t           rr_ptr,
  output logic [NumPorts-1:0] pick,
  output port_idx_t           pick_idx,
  output logic                found
);

  // Scan candidates in pointer order and keep the first hit.
  always_comb begin
    port_idx_t pos;
    pick     = '0;
    pick_idx = 3'd0;
    found    = 1'b0;
    pos      = 3'd0;
    for (int k = 0; k < NumPorts; k++) begin
      pos = port_idx_t'((int'(rr_ptr) + k) % NumPorts);
      if (!found && cand[pos]) begin
        found     = 1'b1;
        pick[pos] = 1'b1;
        pick_idx  = pos;
      end else begin
        found = found;
      end
    end
  end

endmodule

// File: rtl/mux_arbiter.sv
// Switch input arbiter: highest-priority request wins, ties go round-robin,
// and per-port age counters force service of starved inputs.
module mux_arbiter
  import switch_pkg::*;
#(
  parameter int NumPorts      = NUM_PORTS,
  parameter int PriorityWidth = PRIORITY_WIDTH,
  parameter int AgeWidth      = 4,
  parameter int AgeLimit      = 15
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NumPorts-1:0]               req,
  input  logic [NumPorts*PriorityWidth-1:0] prio,
  input  logic                              out_stall,
  output logic [NumPorts-1:0]               grant,
  output logic [2:0]                        grant_index,
  output logic                              grant_valid,
  output logic [NumPorts-1:0]               starved
);

  localparam logic [AgeWidth-1:0] AgeMax = AgeWidth'(AgeLimit);

  port_idx_t                          rr_ptr_q, rr_ptr_d;
  logic [NumPorts-1:0][AgeWidth-1:0]  age_q, age_d;

  logic [PriorityWidth-1:0] max_prio_s;
  logic [NumPorts-1:0]      starved_s;
  logic [NumPorts-1:0]      cand_prio_s;
  logic [NumPorts-1:0]      cand_mask_s;
  logic [NumPorts-1:0]      pick_s;
  port_idx_t                pick_idx_s;
  logic                     pick_found_s;

  // Build the candidate mask: starved requesters override priority.
  always_comb begin
    max_prio_s = '0;
    for (int i = 0; i < NumPorts; i++) begin
      if (req[i] && (prio[i*PriorityWidth +: PriorityWidth] > max_prio_s)) begin
        max_prio_s = prio[i*PriorityWidth +: PriorityWidth];
      end else begin
        max_prio_s = max_prio_s;
      end
    end
    for (int i = 0; i < NumPorts; i++) begin
      starved_s[i]   = (age_q[i] == AgeMax);
      cand_prio_s[i] = req[i] && (prio[i*PriorityWidth +: PriorityWidth] == max_prio_s);
    end
    if (rst || out_stall) begin
      cand_mask_s = '0;
    end else if (|(req & starved_s)) begin
      cand_mask_s = req & starved_s;
    end else begin
      cand_mask_s = cand_prio_s;
    end
  end

  rr_pick #(
    .NumPorts (NumPorts)
  ) u_rr_pick (
    .cand     (cand_mask_s),
    .rr_ptr   (rr_ptr_q),
    .pick     (pick_s),
    .pick_idx (pick_idx_s),
    .found    (pick_found_s)
  );

  // Drive the grant outputs; starved is masked while in reset.
  always_comb begin
    grant       = pick_s;
    grant_valid = pick_found_s;
    if (pick_found_s) begin
      grant_index = pick_idx_s;
    end else begin
      grant_index = 3'd0;
    end
    if (rst) begin
      starved = '0;
    end else begin
      starved = starved_s;
    end
  end

  // Next pointer and ages; a stall freezes ages of ports still requesting.
  always_comb begin
    if (pick_found_s) begin
      rr_ptr_d = next_port(pick_idx_s);
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
    for (int j = 0; j < NumPorts; j++) begin
      if (!req[j]) begin
        age_d[j] = '0;
      end else if (out_stall) begin
        age_d[j] = age_q[j];
      end else if (pick_s[j]) begin
        age_d[j] = '0;
      end else if (age_q[j] == AgeMax) begin
        age_d[j] = AgeMax;
      end else begin
        age_d[j] = age_q[j] + 1'b1;
      end
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= 3'd0;
      age_q    <= '0;
    end else begin
      rr_ptr_q <= rr_ptr_d;
      age_q    <= age_d;
    end
  end

endmodule

// File: tb/tb_mux_arbiter.sv
// Randomized bench for mux_arbiter, checked every cycle against a
// behavioural model of priority / round-robin / aging arbitration.
module tb_mux_arbiter;

  localparam int N  = 7;
  localparam int PW = 8;
  localparam int AL = 15;

  logic            clk = 1'b0;
  logic            rst;
  logic [N-1:0]    req;
  logic [N*PW-1:0] prio;
  logic            out_stall;
  logic [N-1:0]    grant;
  logic [2:0]      grant_index;
  logic            grant_valid;
  logic [N-1:0]    starved;

  int n_vec = 0;
  int n_err = 0;
  int m_ptr;
  int m_age [N];

  always #5 clk = ~clk;

  mux_arbiter dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .prio        (prio),
    .out_stall   (out_stall),
    .grant       (grant),
    .grant_index (grant_index),
    .grant_valid (grant_valid),
    .starved     (starved)
  );

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] want);
    n_vec++;
    if (obs !== want) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, obs, want, $time);
    end
  endtask

  // Apply one cycle of inputs, check outputs mid-cycle, then advance the model.
  task automatic step(input logic r, input logic [N-1:0] rq, input logic [N*PW-1:0] pr,
                      input logic st);
    int cands[$];
    int win, best, best_dist, d;
    logic [N-1:0] exp_g, exp_s;
    @(negedge clk);
    rst = r; req = rq; prio = pr; out_stall = st;
    #1;
    win = -1;
    exp_s = '0;
    for (int i = 0; i < N; i++) if (!r && m_age[i] == AL) exp_s[i] = 1'b1;
    if (!r && !st && rq != '0) begin
      for (int i = 0; i < N; i++) if (rq[i] && m_age[i] == AL) cands.push_back(i);
      if (cands.size() == 0) begin
        best = -1;
        for (int i = 0; i < N; i++) if (rq[i] && int'(pr[i*PW +: PW]) > best) best = int'(pr[i*PW +: PW]);
        for (int i = 0; i < N; i++) if (rq[i] && int'(pr[i*PW +: PW]) == best) cands.push_back(i);
      end
      // nearest candidate at or after the pointer wins
      best_dist = N;
      foreach (cands[k]) begin
        d = (cands[k] - m_ptr + N) % N;
        if (d < best_dist) begin best_dist = d; win = cands[k]; end
      end
    end
    exp_g = '0;
    if (win >= 0) exp_g[win] = 1'b1;
    check_eq("grant", 64'(grant), 64'(exp_g));
    check_eq("grant_index", 64'(grant_index), (win >= 0) ? 64'(win) : 64'd0);
    check_eq("grant_valid", 64'(grant_valid), (win >= 0) ? 64'd1 : 64'd0);
    check_eq("starved", 64'(starved), 64'(exp_s));
    if (r) begin
      m_ptr = 0;
      for (int j = 0; j < N; j++) m_age[j] = 0;
    end else begin
      for (int j = 0; j < N; j++) begin
        if (!rq[j])          m_age[j] = 0;
        else if (st)         m_age[j] = m_age[j];
        else if (j == win)   m_age[j] = 0;
        else if (m_age[j] < AL) m_age[j] = m_age[j] + 1;
      end
      if (win >= 0) m_ptr = (win + 1) % N;
    end
  endtask

  function automatic logic [N*PW-1:0] rand_prio(input int narrow);
    logic [N*PW-1:0] p;
    for (int i = 0; i < N; i++) begin
      if (narrow != 0) p[i*PW +: PW] = PW'($urandom_range(3, 0));
      else             p[i*PW +: PW] = PW'($urandom_range(255, 0));
    end
    return p;
  endfunction

  function automatic logic [N-1:0] rand_req(input int density);
    logic [N-1:0] r;
    for (int i = 0; i < N; i++) r[i] = ($urandom_range(99, 0) < density);
    return r;
  endfunction

  initial begin
    logic [N*PW-1:0] p;
    m_ptr = 0;
    for (int j = 0; j < N; j++) m_age[j] = 0;
    rst = 1'b1; req = '0; prio = '0; out_stall = 1'b0;
    step(1'b1, '0, '0, 1'b0);
    step(1'b1, 7'b1111111, '1, 1'b0);

    // prio0=3, prio2=9: port 2 wins
    p = '0; p[0*PW +: PW] = 8'd3; p[2*PW +: PW] = 8'd9;
    step(1'b0, 7'b0000101, p, 1'b0);
    step(1'b0, 7'b0000000, p, 1'b0);

    // equal priority: pure round-robin with wrap
    p = '0;
    for (int i = 0; i < N; i++) p[i*PW +: PW] = 8'd5;
    for (int c = 0; c < 10; c++) step(1'b0, 7'b1111111, p, 1'b0);

    // low-priority port 6 starves behind port 0, then is served
    p = '0; p[0*PW +: PW] = 8'd200; p[6*PW +: PW] = 8'd1;
    for (int c = 0; c < 40; c++) step(1'b0, 7'b1000001, p, 1'b0);

    // stall with everyone requesting, then release
    p = rand_prio(1);
    for (int c = 0; c < 10; c++) step(1'b0, 7'b1111111, p, 1'b1);
    for (int c = 0; c < 3; c++)  step(1'b0, 7'b1111111, p, 1'b0);

    // port 3 loses repeatedly, drops out mid-age, reasserts
    p = '0; p[0*PW +: PW] = 8'd50; p[3*PW +: PW] = 8'd10;
    for (int c = 0; c < 10; c++) step(1'b0, 7'b0001001, p, 1'b0);
    step(1'b0, 7'b0000001, p, 1'b0);
    for (int c = 0; c < 20; c++) step(1'b0, 7'b0001001, p, 1'b0);

    // reset in the middle of traffic
    step(1'b1, 7'b1111111, p, 1'b0);
    for (int c = 0; c < 3; c++) step(1'b0, 7'b1111111, p, 1'b0);

    // general random traffic
    for (int c = 0; c < 2500; c++) begin
      step(($urandom_range(63, 0) == 0), rand_req(75), rand_prio($urandom_range(1, 0)),
           ($urandom_range(4, 0) == 0));
    end

    // fixed distinct priorities: many ports starve together
    for (int i = 0; i < N; i++) p[i*PW +: PW] = PW'(i * 20);
    for (int c = 0; c < 600; c++) begin
      step(1'b0, rand_req(92), p, ($urandom_range(9, 0) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
